// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: turns the UART byte stream into time/alarm load strobes,
// toggles the alarm enable, and acknowledges every command with one ack byte.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1200,
  parameter logic [7:0]  CR_CHAR     = 8'h0d
) (
  input  logic        clk12m,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_rdy,
  output logic        ld_time,
  output logic        ld_alarm,
  output logic [15:0] ld_digits,
  output logic        alarm_en,
  output logic [7:0]  tx_data,
  output logic        tx_data_rdy,
  output logic        busy
);

  localparam logic [7:0]  ACK_K   = 8'h4b;
  localparam logic [7:0]  ACK_E   = 8'h45;
  localparam logic [7:0]  CH_L    = 8'h6c;
  localparam logic [7:0]  CH_A    = 8'h61;
  localparam logic [7:0]  CH_AT   = 8'h40;
  localparam logic [15:0] TMO_END = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_D0,
    S_D1,
    S_D2,
    S_D3,
    S_WCR
  } state_t;

  state_t      state_q, state_d;
  logic        kind_alarm_q, kind_alarm_d;
  logic [15:0] digits_d;
  logic [15:0] tmo_q, tmo_d;
  logic        alarm_en_d, ld_time_d, ld_alarm_d, tx_rdy_d;
  logic [7:0]  tx_data_d;
  logic [3:0]  nib;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Tens slots (Mtens, Stens) only go up to 5.
  function automatic logic [3:0] digit_limit(input state_t s);
    return ((s == S_D0) || (s == S_D2)) ? 4'd5 : 4'd9;
  endfunction

  assign nib  = rx_data[3:0];
  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    kind_alarm_d = kind_alarm_q;
    digits_d     = ld_digits;
    tmo_d        = tmo_q;
    alarm_en_d   = alarm_en;
    ld_time_d    = 1'b0;
    ld_alarm_d   = 1'b0;
    tx_rdy_d     = 1'b0;
    tx_data_d    = tx_data;
    if (rx_data_rdy) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (rx_data == CH_L) begin
            kind_alarm_d = 1'b0;
            state_d      = S_D0;
          end else if (rx_data == CH_A) begin
            kind_alarm_d = 1'b1;
            state_d      = S_D0;
          end else if (rx_data == CH_AT) begin
            alarm_en_d = ~alarm_en;
            tx_rdy_d   = 1'b1;
            tx_data_d  = ACK_K;
          end
        end
        S_D0, S_D1, S_D2, S_D3: begin
          if (is_digit(rx_data) && (nib <= digit_limit(state_q))) begin
            case (state_q)
              S_D0:    begin digits_d[15:12] = nib; state_d = S_D1;  end
              S_D1:    begin digits_d[11:8]  = nib; state_d = S_D2;  end
              S_D2:    begin digits_d[7:4]   = nib; state_d = S_D3;  end
              default: begin digits_d[3:0]   = nib; state_d = S_WCR; end
            endcase
          end else begin
            tx_rdy_d  = 1'b1;
            tx_data_d = ACK_E;
            state_d   = S_IDLE;
          end
        end
        S_WCR: begin
          tx_rdy_d = 1'b1;
          state_d  = S_IDLE;
          if (rx_data == CR_CHAR) begin
            ld_time_d  = ~kind_alarm_q;
            ld_alarm_d = kind_alarm_q;
            tx_data_d  = ACK_K;
          end else begin
            tx_data_d = ACK_E;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // A byte in the expiry cycle takes the branch above, so it always wins.
      if (tmo_q == TMO_END) begin
        tmo_d     = '0;
        tx_rdy_d  = 1'b1;
        tx_data_d = ACK_E;
        state_d   = S_IDLE;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk12m) begin
    if (rst) begin
      state_q      <= S_IDLE;
      kind_alarm_q <= 1'b0;
      ld_digits    <= '0;
      tmo_q        <= '0;
      alarm_en     <= 1'b0;
      ld_time      <= 1'b0;
      ld_alarm     <= 1'b0;
      tx_data_rdy  <= 1'b0;
      tx_data      <= 8'h00;
    end else begin
      state_q      <= state_d;
      kind_alarm_q <= kind_alarm_d;
      ld_digits    <= digits_d;
      tmo_q        <= tmo_d;
      alarm_en     <= alarm_en_d;
      ld_time      <= ld_time_d;
      ld_alarm     <= ld_alarm_d;
      tx_data_rdy  <= tx_rdy_d;
      tx_data      <= tx_data_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed command scenarios plus randomized command
// streams, all compared every cycle against a command-buffer reference model.
module tb_uart_cmd_ctrl;

  localparam int         T  = 1200;
  localparam logic [7:0] CR = 8'h0d;

  logic        clk12m = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_rdy = 1'b0;
  logic        ld_time, ld_alarm, alarm_en, tx_data_rdy, busy;
  logic [15:0] ld_digits;
  logic [7:0]  tx_data;

  always #5 clk12m = ~clk12m;

  uart_cmd_ctrl #(.TIMEOUT_CYC(T), .CR_CHAR(CR)) dut (
    .clk12m(clk12m), .rst(rst), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
    .ld_time(ld_time), .ld_alarm(ld_alarm), .ld_digits(ld_digits),
    .alarm_en(alarm_en), .tx_data(tx_data), .tx_data_rdy(tx_data_rdy), .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: the bytes of the command collected so far.
  logic [7:0] cmd[$];
  int         quiet;
  logic [3:0] m_dig[4];
  logic       m_alarm, m_ld_time, m_ld_alarm, m_tx_rdy;
  logic [7:0] m_tx;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic m_ack(input logic [7:0] c);
    m_tx_rdy = 1'b1;
    m_tx     = c;
  endtask

  task automatic m_byte(input logic [7:0] b);
    int n, lim;
    n = cmd.size();
    if (n == 0) begin
      if (b == "l" || b == "a") cmd.push_back(b);
      else if (b == "@") begin
        m_alarm = ~m_alarm;
        m_ack("K");
      end
    end else if (n < 5) begin
      lim = ((n - 1) % 2 == 0) ? 5 : 9;
      if (b >= 8'h30 && b <= 8'h39 && int'(b - 8'h30) <= lim) begin
        m_dig[n-1] = 4'(b - 8'h30);
        cmd.push_back(b);
      end else begin
        m_ack("E");
        cmd.delete();
      end
    end else begin
      if (b == CR) begin
        if (cmd[0] == "l") m_ld_time = 1'b1;
        else m_ld_alarm = 1'b1;
        m_ack("K");
      end else m_ack("E");
      cmd.delete();
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [7:0] b);
    m_ld_time = 1'b0; m_ld_alarm = 1'b0; m_tx_rdy = 1'b0;
    if (r) begin
      cmd.delete();
      quiet = 0; m_alarm = 1'b0; m_tx = 8'h00;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    end else if (v) begin
      quiet = 0;
      m_byte(b);
    end else if (cmd.size() != 0) begin
      quiet++;
      if (quiet == T) begin
        m_ack("E");
        cmd.delete();
        quiet = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [7:0] b);
    @(negedge clk12m);
    rst = r; rx_data_rdy = v; rx_data = b;
    @(posedge clk12m);
    model_step(r, v, b);
    #1;
    chk("ld_time", 16'(ld_time), 16'(m_ld_time));
    chk("ld_alarm", 16'(ld_alarm), 16'(m_ld_alarm));
    chk("tx_rdy", 16'(tx_data_rdy), 16'(m_tx_rdy));
    chk("tx_data", 16'(tx_data), 16'(m_tx));
    chk("alarm_en", 16'(alarm_en), 16'(m_alarm));
    chk("busy", 16'(busy), 16'(cmd.size() != 0));
    chk("digits", ld_digits, {m_dig[0], m_dig[1], m_dig[2], m_dig[3]});
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] b;
    int kind;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    chk("reset_tx_data", 16'(tx_data), 16'h0000);
    chk("reset_busy", 16'(busy), 16'h0000);
    idle(2);

    // Time load 58:00
    send("l"); send("5"); send("8"); send("0"); send("0"); send(CR);
    chk("t1_ld_time", 16'(ld_time), 16'h0001);
    chk("t1_digits", ld_digits, 16'h5800);
    chk("t1_ack", 16'(tx_data), 16'h004b);
    idle(2);
    chk("t1_digits_hold", ld_digits, 16'h5800);

    // Alarm load 59:20 then toggle enable twice
    send("a"); send("5"); send("9"); send("2"); send("0"); send(CR);
    chk("t2_ld_alarm", 16'(ld_alarm), 16'h0001);
    chk("t2_digits", ld_digits, 16'h5920);
    idle(1);
    send("@");
    chk("t2_alarm_on", 16'(alarm_en), 16'h0001);
    chk("t2_at_ack", 16'(tx_data_rdy), 16'h0001);
    send("@");
    chk("t2_alarm_off", 16'(alarm_en), 16'h0000);

    // Mtens out of range
    send("l"); send("6");
    chk("t3_err", 16'(tx_data), 16'h0045);
    chk("t3_idle", 16'(busy), 16'h0000);
    send("0"); send("0"); send("0");
    idle(2);

    // Bad terminator, then stray CR in IDLE
    send("a"); send("1"); send("2"); send("3"); send("4"); send("x");
    chk("t4_err", 16'(tx_data), 16'h0045);
    chk("t4_no_load", 16'(ld_alarm), 16'h0000);
    send(CR);
    chk("t4_stray_cr", 16'(tx_data_rdy), 16'h0000);
    idle(2);

    // Byte landing on the expiry cycle keeps the command alive
    send("l"); send("1"); send("2");
    idle(T - 1);
    chk("t5_still_busy", 16'(busy), 16'h0001);
    send("3");
    chk("t5_byte_wins", 16'(tx_data_rdy), 16'h0000);
    send("4"); send(CR);
    chk("t5_load", ld_digits, 16'h1234);

    // Silence until timeout
    send("l"); send("1"); send("2");
    idle(T - 1);
    chk("t5_pre_tmo", 16'(tx_data_rdy), 16'h0000);
    idle(1);
    chk("t5_tmo_ack", 16'(tx_data), 16'h0045);
    chk("t5_tmo_idle", 16'(busy), 16'h0000);
    idle(2);

    // Reset mid-command, then back-to-back command
    send("@");
    send("l"); send("1");
    step(1'b1, 1'b0, 8'h00);
    chk("t6_rst_alarm", 16'(alarm_en), 16'h0000);
    chk("t6_rst_tx", 16'(tx_data_rdy), 16'h0000);
    send("l"); send("0"); send("0"); send("0"); send("1"); send(CR);
    chk("t6_ld_time", 16'(ld_time), 16'h0001);
    chk("t6_digits", ld_digits, 16'h0001);

    // Randomized command streams
    for (int c = 0; c < 200; c++) begin
      kind = int'($urandom_range(0, 5));
      if (kind == 0) send("@");
      else if (kind == 1) begin
        b = 8'($urandom_range(0, 255));
        send(b);
      end else begin
        send((kind % 2 == 0) ? 8'h6c : 8'h61);
        for (int d = 0; d < 4; d++) begin
          idle(int'($urandom_range(0, 2)));
          if ($urandom_range(0, 15) == 0) b = 8'h40;
          else if (d % 2 == 0 && $urandom_range(0, 7) != 0) b = 8'(8'h30 + $urandom_range(0, 5));
          else b = 8'(8'h30 + $urandom_range(0, 9));
          send(b);
        end
        idle(int'($urandom_range(0, 2)));
        send(($urandom_range(0, 7) == 0) ? 8'h78 : CR);
      end
      idle(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
